// File: rtl/addsub_nibble_sequencer.sv
// Arbitrates two requesters onto one shared 4-bit adder and runs each multi-nibble
// add or subtract LSB nibble first, chaining the carry through a register.
module addsub_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [4*NIBBLES-1:0]   req0_a,
   input  logic [4*NIBBLES-1:0]   req0_b,
   input  logic                   req0_k,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [4*NIBBLES-1:0]   req1_a,
   input  logic [4*NIBBLES-1:0]   req1_b,
   input  logic                   req1_k,
   output logic [3:0]             nib_a,
   output logic [3:0]             nib_b,
   output logic                   nib_cin,
   output logic                   nib_k,
   input  logic [3:0]             nib_sum,
   input  logic                   nib_cout,
   output logic                   res_valid,
   output logic                   res_id,
   output logic [4*NIBBLES-1:0]   res_data,
   output logic                   res_flag,
   output logic                   busy
);

   // state | meaning
   // IDLE  | waiting for a request; ready offered to the granted requester
   // RUN   | one nibble per cycle through the shared adder, idx = nibble index
   // DONE  | last nibble done; result and flag registered, strobe follows

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] idx;
   logic          carry;
   logic          rr_last;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic          k_q;
   logic          id_q;
   logic          grant;
   logic          hs;
   logic          last_nib;

   assign last_nib = (idx == IW'(NIBBLES - 1));

   // On a tie the requester not served last wins; with one valid it simply wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~rr_last;
      else if (req1_valid)
         grant = 1'b1;
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst && state == S_IDLE) begin
         req0_ready = req0_valid && !grant;
         req1_ready = req1_valid &&  grant;
      end
   end

   assign hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      nib_a     = 4'h0;
      nib_b     = 4'h0;
      nib_cin   = 1'b0;
      nib_k     = 1'b0;
      case (state)
         S_IDLE: begin
            if (hs)
               state_nxt = S_RUN;
         end
         S_RUN: begin
            busy    = 1'b1;
            nib_a   = a_q[4*idx +: 4];
            nib_b   = k_q ? ~b_q[4*idx +: 4] : b_q[4*idx +: 4];
            nib_cin = carry;
            if (last_nib)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         rr_last   <= 1'b1;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         k_q       <= 1'b0;
         id_q      <= 1'b0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         res_data  <= '0;
         res_flag  <= 1'b0;
      end else begin
         state     <= state_nxt;
         res_valid <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (hs) begin
                  a_q     <= grant ? req1_a : req0_a;
                  b_q     <= grant ? req1_b : req0_b;
                  k_q     <= grant ? req1_k : req0_k;
                  carry   <= grant ? req1_k : req0_k;
                  id_q    <= grant;
                  rr_last <= grant;
                  idx     <= '0;
               end
            end
            S_RUN: begin
               sum_q[4*idx +: 4] <= nib_sum;
               carry             <= nib_cout;
               idx               <= idx + 1'b1;
            end
            S_DONE: begin
               // Subtract ran as a + ~b + 1, so a missing carry means a borrow.
               res_data <= sum_q;
               res_flag <= k_q ? ~carry : carry;
               res_id   <= id_q;
            end
            default: ;
         endcase
      end
   end

endmodule
